// File: rtl/calc_pkg.sv
// calc_pkg: mode and FSM encodings shared by the sequential calculator.
package calc_pkg;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;
  function automatic logic [2:0] op_onehot(input logic [1:0] m);
    return m == MODE_ADD ? 3'b001 : m == MODE_SUB ? 3'b010 : m == MODE_MUL ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: shared accumulator doing shift-add multiply or restoring divide, one bit per step.
module seq_muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [2*WIDTH-1:0] acc_q, acc_d, div_nxt;
  logic [WIDTH-1:0] b_q, b_d;
  logic div_q, div_d, ge;
  logic [WIDTH:0] mul_sum, rem_sh, diff;
  // acc = {partial/remainder, multiplier/quotient}; lower half shifts out as upper half fills
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff = rem_sh - {1'b0, b_q};
    ge = ~diff[WIDTH];
    div_nxt = ge ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    acc_d = load ? {{WIDTH{1'b0}}, a} : step ? (div_q ? div_nxt : {mul_sum, acc_q[WIDTH-1:1]}) : acc_q;
    b_d = load ? b : b_q;
    div_d = load ? is_div : div_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q <= b_d;
      div_q <= div_d;
    end
  end
  assign acc_out = acc_q;
endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle add/sub/mul/div with start/done handshake and registered results.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               sgn,
  output logic               div_by_zero,
  output logic [2:0]         op_active
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d, acc;
  logic [2:0] op_q, op_d;
  logic carry_q, carry_d, sgn_q, sgn_d, dbz_q, dbz_d, run_q, run_d;
  logic [WIDTH:0] sum;
  logic lt, zero_div, is_md, go, load, step, fin, last;
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign lt = a < b;
  assign zero_div = mode == MODE_DIV && b == '0;
  assign is_md = mode[1] && !zero_div;
  assign go = state_q == ST_IDLE && start;
  assign load = go && is_md;
  assign step = state_q == ST_RUN;
  assign fin = state_q == ST_FIN;
  assign last = cnt_q == CW'(WIDTH - 1);
  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .is_div(mode[0]),
    .a(a),
    .b(b),
    .step(step),
    .acc_out(acc)
  );
  // single-cycle ops commit on the capture edge; mul/div commit from the core while leaving FIN
  always_comb begin
    state_d = go ? (is_md ? ST_RUN : ST_FIN) : step ? (last ? ST_FIN : ST_RUN) : ST_IDLE;
    cnt_d = step && !last ? cnt_q + 1'b1 : '0;
    run_d = go ? is_md : run_q;
    op_d = go ? op_onehot(mode) : fin ? 3'b000 : op_q;
    res_d = go && !is_md ? (mode == MODE_ADD ? {{WIDTH{1'b0}}, sum[WIDTH-1:0]} :
                            mode == MODE_SUB ? {{WIDTH{1'b0}}, lt ? b - a : a - b} :
                            {a, {WIDTH{1'b1}}}) :
            fin && run_q ? acc : res_q;
    carry_d = go && !is_md ? mode == MODE_ADD && sum[WIDTH] : step && last ? 1'b0 : carry_q;
    sgn_d = go && !is_md ? mode == MODE_SUB && lt : step && last ? 1'b0 : sgn_q;
    dbz_d = go && !is_md ? zero_div : step && last ? 1'b0 : dbz_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      run_q <= 1'b0;
      op_q <= 3'b000;
      res_q <= '0;
      carry_q <= 1'b0;
      sgn_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      op_q <= op_d;
      res_q <= res_d;
      carry_q <= carry_d;
      sgn_q <= sgn_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = fin;
  assign result = fin && run_q ? acc : res_q;
  assign carry = carry_q;
  assign sgn = sgn_q;
  assign div_by_zero = dbz_q;
  assign op_active = op_q;
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed and random ops checked against a queued reference model.
module tb_seq_calculator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic busy, done, carry, sgn, div_by_zero;
  logic [15:0] result;
  logic [2:0] op_active;
  typedef struct {
    logic [15:0] res;
    logic c, s, z;
    int lat;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  seq_calculator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry(carry), .sgn(sgn),
    .div_by_zero(div_by_zero), .op_active(op_active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [1:0] m, input logic [7:0] aa, input logic [7:0] bb, input logic ci, input int glitch);
    exp_t e, g;
    int lat, s;
    logic [2:0] oh;
    s = int'(aa) + int'(bb) + int'(ci);
    e.c = 0; e.s = 0; e.z = 0; e.lat = 1;
    if (m == 2'b00) begin e.res = 16'(s % 256); e.c = s > 255; end
    else if (m == 2'b01) begin e.res = aa < bb ? 16'(bb - aa) : 16'(aa - bb); e.s = aa < bb; end
    else if (m == 2'b10) begin e.res = 16'(int'(aa) * int'(bb)); e.lat = 9; end
    else if (bb == 0) begin e.res = {aa, 8'hFF}; e.z = 1; end
    else begin e.res = {8'(aa % bb), 8'(aa / bb)}; e.lat = 9; end
    oh = m == 2'b00 ? 3'b001 : m == 2'b01 ? 3'b010 : m == 2'b10 ? 3'b100 : 3'b000;
    q.push_back(e);
    mode = m; a = aa; b = bb; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk("op_active", 32'(op_active), 32'(oh));
    while (!done && lat < 40) begin
      chk("busy_run", 32'(busy), 1);
      if (lat == glitch) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk("done", 32'(done), 1);
    g = q.pop_front();
    chk("latency", lat, g.lat);
    chk("result", 32'(result), 32'(g.res));
    chk("carry", 32'(carry), 32'(g.c));
    chk("sgn", 32'(sgn), 32'(g.s));
    chk("div_by_zero", 32'(div_by_zero), 32'(g.z));
    chk("busy_fin", 32'(busy), 1);
    @(negedge clk);
    chk("done_once", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_op", 32'(op_active), 0);
    chk("hold", 32'(result), 32'(g.res));
  endtask
  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'({carry, sgn, div_by_zero}), 0);
    chk("rst_op", 32'(op_active), 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 8'd200, 8'd100, 1'b1, -1);
    do_op(2'b01, 8'd5, 8'd9, 1'b0, -1);
    do_op(2'b01, 8'd9, 8'd5, 1'b0, -1);
    do_op(2'b10, 8'd255, 8'd255, 1'b0, -1);
    do_op(2'b11, 8'd100, 8'd7, 1'b0, -1);
    do_op(2'b11, 8'd100, 8'd0, 1'b0, -1);
    do_op(2'b10, 8'd13, 8'd11, 1'b0, 3);
    mode = 2'b10; a = 8'd13; b = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_op", 32'(op_active), 0);
    dn = 0;
    repeat (12) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", dn, 0);
    for (int i = 0; i < 24; i++)
      do_op(2'($urandom_range(3)), 8'($urandom), ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom), 1'($urandom), -1);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
